// File: rtl/spi_reg_burst.sv
// spi_reg_burst: SPI target bridging a host to a register bus, all four SPI modes,
// burst reads/writes with optional address auto-increment until chip-select rises.
module spi_reg_burst #(
    parameter int ADDR_W = 6,
    parameter int REG_W  = 32,
    parameter bit CPOL   = 1'b0,
    parameter bit CPHA   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [7:0]        status,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [REG_W-1:0]  reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [REG_W-1:0]  reg_rdata,
    output logic              frame_active,
    output logic              frame_err
);
    localparam int CNT_W = $clog2(REG_W) + 1;
    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;
    state_t state, state_nxt;
    logic [1:0] sck_s, cs_s, mosi_s, vld;
    logic sck_d, cs_d, armed, fresh, inc, load_pend;
    logic [CNT_W-1:0] bit_cnt, cnt_nxt;
    logic [REG_W-2:0] rx_sh;
    logic [REG_W-1:0] rx_nxt, tx_sh;
    logic sck_edge, sample, change, cs_fall, cs_rise, cmd_done, word_done;

    assign sck_edge = state != IDLE && sck_s[1] != sck_d;
    assign sample = sck_edge && (CPHA ? sck_s[1] == CPOL : sck_d == CPOL);
    assign change = sck_edge && (CPHA ? sck_d == CPOL : sck_s[1] == CPOL);
    // a frame may only start once a genuine high CS has reached the synchroniser output
    assign cs_fall = armed && cs_d && !cs_s[1];
    assign cs_rise = !cs_d && cs_s[1];
    assign rx_nxt = {rx_sh, mosi_s[1]};
    assign cmd_done = state == CMD && sample && bit_cnt == CNT_W'(7);
    assign word_done = (state == WR || state == RD) && sample && bit_cnt == CNT_W'(REG_W - 1);
    assign spi_miso = tx_sh[REG_W-1];
    assign frame_active = state != IDLE;

    always_comb begin
        state_nxt = state;
        cnt_nxt = sample ? ((cmd_done || word_done) ? '0 : bit_cnt + 1'b1) : bit_cnt;
        if (state == IDLE && cs_fall) begin
            state_nxt = CMD;
            cnt_nxt = '0;
        end else if (cmd_done)
            state_nxt = rx_nxt[7] ? WR : RD;
        if (state != IDLE && cs_rise)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else if (ena)
            state <= state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_s <= {2{CPOL}};
            cs_s <= 2'b11;
            mosi_s <= 2'b00;
            vld <= 2'b00;
            sck_d <= CPOL;
            cs_d <= 1'b1;
            armed <= 1'b0;
            bit_cnt <= '0;
            rx_sh <= '0;
            tx_sh <= '0;
            fresh <= 1'b0;
            inc <= 1'b0;
            load_pend <= 1'b0;
            reg_addr <= '0;
            reg_wdata <= '0;
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            frame_err <= 1'b0;
        end else if (ena) begin
            sck_s <= {sck_s[0], spi_sck};
            cs_s <= {cs_s[0], spi_cs_n};
            mosi_s <= {mosi_s[0], spi_mosi};
            vld <= {vld[0], 1'b1};
            sck_d <= sck_s[1];
            cs_d <= cs_s[1];
            armed <= armed | (vld[1] & cs_s[1]);
            bit_cnt <= cnt_nxt;
            if (sample)
                rx_sh <= rx_nxt[REG_W-2:0];
            reg_we <= word_done && state == WR;
            reg_re <= cmd_done ? !rx_nxt[7] : word_done && state == RD;
            load_pend <= reg_re;
            frame_err <= state != IDLE && cs_rise && cnt_nxt != '0;
            if (word_done && state == WR)
                reg_wdata <= rx_nxt;
            if (cmd_done) begin
                inc <= rx_nxt[6];
                reg_addr <= rx_nxt[ADDR_W-1:0];
            end else if ((reg_we || (word_done && state == RD)) && inc)
                reg_addr <= reg_addr + 1'b1;
            // a fresh load survives the next change edge so its MSB is sampled first
            if (state == IDLE && cs_fall) begin
                tx_sh <= REG_W'(status) << (REG_W - 8);
                fresh <= CPHA;
            end else if (load_pend && state == RD) begin
                tx_sh <= reg_rdata;
                fresh <= 1'b1;
            end else if (change) begin
                fresh <= 1'b0;
                if (!fresh)
                    tx_sh <= tx_sh << 1;
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_burst.sv
// tb_spi_reg_burst: one target per SPI mode, driven by a bit-level host and checked
// against a frame-level model of strobes, addresses and returned data.
module tb_spi_reg_burst;
    localparam int H = 6;
    logic clk = 1'b0, rst = 1'b1, ena = 1'b1;
    logic [3:0] sck = 4'b1100, cs_n = 4'hf, mosi = 4'h0, miso, we, re, fa, err;
    logic [7:0] status = 8'h00;
    logic [5:0] addr [4];
    logic [31:0] wdata [4], rdata [4], mem [64];
    logic tx_bits[$], rx_bits[$];
    logic [31:0] wr_words[$], fixed[$];
    logic [37:0] we_log[$];
    logic [5:0] re_log[$];
    int err_n = 0, m_act = 0, total = 0, bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_reg_burst #(.ADDR_W(6), .REG_W(32), .CPOL(g >= 2), .CPHA(g % 2 == 1)) u_dut (
            .clk(clk), .rst(rst), .ena(ena), .spi_sck(sck[g]), .spi_cs_n(cs_n[g]),
            .spi_mosi(mosi[g]), .spi_miso(miso[g]), .status(status), .reg_addr(addr[g]),
            .reg_wdata(wdata[g]), .reg_we(we[g]), .reg_re(re[g]), .reg_rdata(rdata[g]),
            .frame_active(fa[g]), .frame_err(err[g]));
    end

    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (re[i] && ena) rdata[i] <= mem[addr[i]];

    always @(negedge clk)
        if (ena) begin
            if (we[m_act]) we_log.push_back({addr[m_act], wdata[m_act]});
            if (re[m_act]) re_log.push_back(addr[m_act]);
            if (err[m_act]) err_n++;
        end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_val(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) tx_bits.push_back(v[i]);
    endtask

    function automatic logic [31:0] rx_val(input int off, input int n);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v = {v[30:0], rx_bits[off + i]};
        return v;
    endfunction

    task automatic setup(input logic [7:0] cmd, input int nbits);
        logic [31:0] w;
        tx_bits.delete();
        wr_words.delete();
        push_val(32'(cmd), 8);
        while (tx_bits.size() < nbits) begin
            w = fixed.size() != 0 ? fixed.pop_front() : $urandom;
            wr_words.push_back(w);
            push_val(w, 32);
        end
        while (tx_bits.size() > nbits) void'(tx_bits.pop_back());
    endtask

    task automatic xfer_bit(input int m, input logic b, output logic r);
        logic cpol, cpha;
        cpol = m >= 2;
        cpha = m % 2 == 1;
        if (!cpha) begin
            mosi[m] = b;
            clks(H);
            r = miso[m];
            sck[m] = ~cpol;
            clks(H);
            sck[m] = cpol;
        end else begin
            sck[m] = ~cpol;
            mosi[m] = b;
            clks(H);
            r = miso[m];
            sck[m] = cpol;
            clks(H);
        end
    endtask

    task automatic run_frame(input int m, input int nbits, input int hold);
        logic r;
        rx_bits.delete();
        m_act = m;
        cs_n[m] = 1'b0;
        clks(8);
        chk("active", fa[m], 1);
        for (int i = 0; i < nbits; i++) begin
            if (i == hold) begin
                ena = 1'b0;
                clks(20);
                ena = 1'b1;
            end
            xfer_bit(m, tx_bits[i], r);
            rx_bits.push_back(r);
        end
        clks(8);
        cs_n[m] = 1'b1;
        clks(12);
        chk("inactive", fa[m], 0);
    endtask

    task automatic check_frame(input logic [7:0] cmd, input int nbits, input logic [7:0] st);
        int nw, exp_err, step;
        logic [5:0] a;
        a = cmd[5:0];
        step = cmd[6] ? 1 : 0;
        nw = nbits < 8 ? 0 : (nbits - 8) / 32;
        exp_err = nbits < 8 ? int'(nbits != 0) : int'((nbits - 8) % 32 != 0);
        chk("frame_err", 64'(err_n), 64'(exp_err));
        if (nbits >= 8) chk("status", rx_val(0, 8), 64'(st));
        if (cmd[7]) begin
            chk("we_count", 64'(we_log.size()), 64'(nw));
            chk("re_count_wr", 64'(re_log.size()), 0);
            for (int k = 0; k < nw && k < we_log.size(); k++) begin
                chk("we", we_log[k], {6'(a + step * k), wr_words[k]});
                chk("miso_wr", rx_val(8 + 32 * k, 32), 0);
            end
        end else begin
            chk("re_count", 64'(re_log.size()), 64'(nbits >= 8 ? nw + 1 : 0));
            chk("we_count_rd", 64'(we_log.size()), 0);
            for (int k = 0; k < re_log.size() && k <= nw; k++)
                chk("re_addr", re_log[k], 64'(6'(a + step * k)));
            for (int k = 0; k < nw; k++)
                chk("rdata", rx_val(8 + 32 * k, 32), mem[6'(a + step * k)]);
        end
        we_log.delete();
        re_log.delete();
        err_n = 0;
    endtask

    task automatic do_frame(input int m, input logic [7:0] cmd, input int nbits, input int hold);
        logic [7:0] st;
        st = 8'($urandom);
        status = st;
        setup(cmd, nbits);
        run_frame(m, nbits, hold);
        check_frame(cmd, nbits, st);
    endtask

    initial begin
        logic r;
        int m, nbits, hold;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        clks(4);
        for (int i = 0; i < 4; i++)
            chk("reset", {miso[i], we[i], re[i], fa[i], err[i], addr[i], wdata[i]}, 0);
        rst = 1'b0;
        clks(6);
        fixed.push_back(32'h11223344);
        fixed.push_back(32'h55667788);
        do_frame(0, 8'hC2, 8 + 64, -1);
        do_frame(3, 8'h7E, 8 + 96, -1);
        do_frame(1, 8'h85, 8 + 96, -1);
        do_frame(0, 8'hC2, 8 + 13, -1);
        do_frame(0, 8'hC2, 8 + 32, -1);
        do_frame(2, 8'hE0, 8 + 64, 20);
        do_frame(3, 8'h41, 8 + 64, 45);
        m_act = 0;
        status = 8'h3C;
        setup(8'h41, 8 + 64);
        cs_n[0] = 1'b0;
        clks(8);
        for (int i = 0; i < 18; i++) xfer_bit(0, tx_bits[i], r);
        we_log.delete();
        re_log.delete();
        err_n = 0;
        rst = 1'b1;
        clks(2);
        chk("rst_mid", {miso[0], we[0], re[0], fa[0], err[0], addr[0], wdata[0]}, 0);
        rst = 1'b0;
        for (int i = 18; i < 72; i++) xfer_bit(0, tx_bits[i], r);
        chk("rst_idle", fa[0], 0);
        clks(8);
        cs_n[0] = 1'b1;
        clks(12);
        chk("rst_re", 64'(re_log.size()), 0);
        chk("rst_we", 64'(we_log.size()), 0);
        chk("rst_err", 64'(err_n), 0);
        do_frame(0, 8'h41, 8 + 64, -1);
        for (int t = 0; t < 12; t++) begin
            m = $urandom_range(0, 3);
            nbits = 8 + 32 * $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) nbits += $urandom_range(1, 31);
            hold = $urandom_range(0, 2) == 0 ? $urandom_range(0, nbits - 1) : -1;
            do_frame(m, 8'($urandom), nbits, hold);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
